// File: rtl/cpu_pkg.sv
// Shared definitions for the program sequencer and the processor it drives:
// opcode encodings, sequencer state encoding and instruction-field helpers.
package cpu_pkg;

  localparam int unsigned WORD_W = 9;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_4   = 3'b100;
  localparam logic [2:0] OP_5   = 3'b101;
  localparam logic [2:0] OP_6   = 3'b110;
  localparam logic [2:0] OP_7   = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_ISSUE = 3'd2,
    ST_LOAD  = 3'd3,
    ST_IMM   = 3'd4,
    ST_WAIT  = 3'd5,
    ST_HALT  = 3'd6
  } seq_state_e;

  function automatic logic [2:0] opcode_of(input logic [WORD_W-1:0] word);
    return word[8:6];
  endfunction

endpackage

// File: rtl/prog_counter.sv
// Program counter with sticky end-of-program flag; the flag sets on any
// increment that lands on prog_len (modulo 2^PC_W, so 0 means full wrap).
module prog_counter #(
  parameter int PC_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            clr,
  input  logic            inc,
  input  logic [PC_W-1:0] prog_len,
  output logic [PC_W-1:0] pc,
  output logic            end_flag
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            end_q, end_d;

  always_comb begin
    pc_d  = pc_q;
    end_d = end_q;
    if (clr) begin
      pc_d  = '0;
      end_d = 1'b0;
    end else if (inc) begin
      pc_d = pc_q + PC_W'(1);
      if (pc_d == prog_len) end_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      end_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      end_q <= end_d;
    end
  end

  assign pc       = pc_q;
  assign end_flag = end_q;

endmodule

// File: rtl/prog_sequencer.sv
// Feeds a program from a synchronous ROM into a simple processor, one
// instruction (plus optional immediate) per cpu_run handshake.
//
// state | meaning
// IDLE  | after reset, waiting for start
// FETCH | ROM address presented, data arrives next cycle
// ISSUE | waiting for cpu_done, then pulse cpu_run and register the word
// LOAD  | processor loads IR from din; ROM addressed at the next word
// IMM   | register the immediate word for move-immediate
// WAIT  | waiting for cpu_done to retire the instruction
// HALT  | program finished, waiting for start
module prog_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [PC_W-1:0]  prog_len,
  output logic [PC_W-1:0]  rom_addr,
  input  logic [8:0]       rom_data,
  output logic [8:0]       din,
  output logic             cpu_run,
  input  logic             cpu_done,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] instr_cnt
);

  seq_state_e        state_q, state_d;
  logic [8:0]        din_q, din_d;
  logic [2:0]        op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              pc_clr, pc_inc, run;
  logic [PC_W-1:0]   pc;
  logic              end_flag;

  prog_counter #(.PC_W(PC_W)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .clr      (pc_clr),
    .inc      (pc_inc),
    .prog_len (prog_len),
    .pc       (pc),
    .end_flag (end_flag)
  );

  always_comb begin
    state_d = state_q;
    din_d   = din_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    pc_clr  = 1'b0;
    pc_inc  = 1'b0;
    run     = 1'b0;
    case (state_q)
      ST_IDLE, ST_HALT: begin
        if (start) begin
          state_d = ST_FETCH;
          pc_clr  = 1'b1;
          cnt_d   = '0;
        end
      end
      ST_FETCH: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (cpu_done) begin
          run     = 1'b1;
          din_d   = rom_data;
          op_d    = opcode_of(rom_data);
          pc_inc  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: state_d = (op_q == OP_MVI) ? ST_IMM : ST_WAIT;
      ST_IMM: begin
        // ROM was addressed at pc during LOAD, so the immediate is on rom_data now
        din_d   = rom_data;
        pc_inc  = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cpu_done) begin
          if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
          state_d = end_flag ? ST_HALT : ST_FETCH;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      din_q   <= '0;
      op_q    <= OP_MV;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      din_q   <= din_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rom_addr  = pc;
  assign din       = din_q;
  assign cpu_run   = run;
  assign busy      = (state_q != ST_IDLE) && (state_q != ST_HALT);
  assign halted    = (state_q == ST_HALT);
  assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_prog_sequencer.sv
// Bench for prog_sequencer: three parameterisations behind one selector,
// a table of directed programs, hand-written corner sequences and random programs.
module tb_prog_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start, stall;
  int         sel;
  logic [7:0] plen;
  logic [8:0] rom [256];

  logic [7:0]  addr_a;  logic [8:0] rd_a, din_a;  logic run_a, busy_a, halt_a, done_a, start_a;  logic [15:0] cnt_a;
  logic [2:0]  addr_b;  logic [8:0] rd_b, din_b;  logic run_b, busy_b, halt_b, done_b, start_b;  logic [15:0] cnt_b;
  logic [7:0]  addr_c;  logic [8:0] rd_c, din_c;  logic run_c, busy_c, halt_c, done_c, start_c;  logic [1:0]  cnt_c;

  int   proc_cnt = 0;
  int   lat_min, lat_max;
  logic rst_q = 1'b1;
  logic cpu_done;

  assign cpu_done = (proc_cnt == 0) && !stall;
  assign done_a   = (sel == 0) ? cpu_done : 1'b1;
  assign done_b   = (sel == 1) ? cpu_done : 1'b1;
  assign done_c   = (sel == 2) ? cpu_done : 1'b1;
  assign start_a  = start && (sel == 0);
  assign start_b  = start && (sel == 1);
  assign start_c  = start && (sel == 2);

  prog_sequencer #(.PC_W(8), .CNT_W(16)) u_a (
    .clk(clk), .reset(reset), .start(start_a), .prog_len(plen), .rom_addr(addr_a),
    .rom_data(rd_a), .din(din_a), .cpu_run(run_a), .cpu_done(done_a), .busy(busy_a),
    .halted(halt_a), .instr_cnt(cnt_a));
  prog_sequencer #(.PC_W(3), .CNT_W(16)) u_b (
    .clk(clk), .reset(reset), .start(start_b), .prog_len(plen[2:0]), .rom_addr(addr_b),
    .rom_data(rd_b), .din(din_b), .cpu_run(run_b), .cpu_done(done_b), .busy(busy_b),
    .halted(halt_b), .instr_cnt(cnt_b));
  prog_sequencer #(.PC_W(8), .CNT_W(2)) u_c (
    .clk(clk), .reset(reset), .start(start_c), .prog_len(plen), .rom_addr(addr_c),
    .rom_data(rd_c), .din(din_c), .cpu_run(run_c), .cpu_done(done_c), .busy(busy_c),
    .halted(halt_c), .instr_cnt(cnt_c));

  // selected DUT viewed through one set of signals
  logic        run_m, busy_m, halt_m;
  logic [8:0]  din_m;
  logic [7:0]  addr_m;
  logic [15:0] cnt_m;
  always_comb begin
    run_m = run_a; busy_m = busy_a; halt_m = halt_a; din_m = din_a; addr_m = addr_a; cnt_m = cnt_a;
    if (sel == 1) begin
      run_m = run_b; busy_m = busy_b; halt_m = halt_b; din_m = din_b; addr_m = {5'b0, addr_b}; cnt_m = cnt_b;
    end else if (sel == 2) begin
      run_m = run_c; busy_m = busy_c; halt_m = halt_c; din_m = din_c; addr_m = addr_c; cnt_m = {14'b0, cnt_c};
    end
  end

  // synchronous ROMs and a processor that stays busy a few cycles per run
  always @(posedge clk) begin
    rd_a  <= rom[addr_a];
    rd_b  <= rom[{5'b0, addr_b}];
    rd_c  <= rom[addr_c];
    rst_q <= reset;
    if (reset)              proc_cnt <= 0;
    else if (run_m)         proc_cnt <= int'($urandom_range(lat_max, lat_min));
    else if (proc_cnt > 0)  proc_cnt <= proc_cnt - 1;
  end

  // monitor: captures instruction word 1 cycle and immediate 3 cycles after run
  logic [8:0] obs_w[$];
  int         run_cnt = 0, prot_err = 0, since_run = 100, sel_prev = 0;
  logic       run_prev = 1'b0;
  logic [8:0] din_prev = 9'h0;
  always @(negedge clk) begin
    #2;
    if (run_m) begin
      if (run_prev || !busy_m) prot_err++;
      run_cnt++;
      since_run = 0;
    end else if (since_run < 100) begin
      since_run++;
    end
    if (since_run == 1) obs_w.push_back(din_m);
    if (since_run == 3 && obs_w.size() > 0 && obs_w[obs_w.size()-1][8:6] == OP_MVI)
      obs_w.push_back(din_m);
    if (din_m !== din_prev && since_run != 1 && since_run != 3 && !rst_q && sel == sel_prev)
      prot_err++;
    din_prev = din_m;
    run_prev = run_m;
    sel_prev = sel;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // reference: walk the ROM word by word until the position reaches the program end
  logic [8:0] exp_w[$];
  int exp_n, exp_pc;
  task automatic ref_build(input int pcw, input int pl);
    int size, limit, pos;
    logic [8:0] w;
    size = 1 << pcw;
    limit = (pl == 0) ? size : pl;
    pos = 0;
    exp_w.delete();
    exp_n = 0;
    while (pos < limit) begin
      w = rom[8'(pos % size)];
      exp_w.push_back(w);
      pos++;
      if (w[8:6] == OP_MVI) begin
        exp_w.push_back(rom[8'(pos % size)]);
        pos++;
      end
      exp_n++;
    end
    exp_pc = pos % size;
  endtask

  task automatic run_prog(input string tag, input bit noise);
    int cmax, cyc, bad_idx;
    cmax = (sel == 2) ? 3 : 65535;
    ref_build((sel == 1) ? 3 : 8, (sel == 1) ? int'(plen[2:0]) : int'(plen));
    @(negedge clk);
    obs_w.delete();
    run_cnt = 0;
    prot_err = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!halt_m && cyc < 5000) begin
      start = noise && busy_m && ($urandom_range(3, 0) == 0);
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    #3;
    check({tag, " finished"}, cyc < 5000, 1);
    check({tag, " runs"}, run_cnt, exp_n);
    check({tag, " instr_cnt"}, cnt_m, (exp_n > cmax) ? cmax : exp_n);
    check({tag, " final pc"}, addr_m, exp_pc);
    check({tag, " halted/busy"}, {halt_m, busy_m}, 2'b10);
    check({tag, " protocol errors"}, prot_err, 0);
    check({tag, " word count"}, obs_w.size(), exp_w.size());
    bad_idx = -1;
    for (int k = 0; k < obs_w.size() && k < exp_w.size(); k++)
      if (bad_idx < 0 && obs_w[k] !== exp_w[k]) bad_idx = k;
    check({tag, " first bad word index"}, bad_idx, -1);
  endtask

  typedef struct {
    int               sel;
    int               plen;
    logic [0:7][8:0]  w;
    int               runs;
    int               cnt;
    int               pc;
  } vec_t;
  vec_t vt[8];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, cyc;
    bit ok_stall;
    vt[0] = '{0, 1, {9'o010, 9'o0, 9'o0, 9'o0, 9'o0, 9'o0, 9'o0, 9'o0}, 1, 1, 1};
    vt[1] = '{0, 2, {9'o100, 9'h05A, 9'o0, 9'o0, 9'o0, 9'o0, 9'o0, 9'o0}, 1, 1, 2};
    vt[2] = '{0, 3, {9'o010, 9'o110, 9'h1FF, 9'o0, 9'o0, 9'o0, 9'o0, 9'o0}, 2, 2, 3};
    vt[3] = '{0, 1, {9'o100, 9'h033, 9'o0, 9'o0, 9'o0, 9'o0, 9'o0, 9'o0}, 1, 1, 2};
    vt[4] = '{1, 0, {9'o010, 9'o010, 9'o010, 9'o010, 9'o010, 9'o010, 9'o010, 9'o010}, 8, 8, 0};
    vt[5] = '{1, 0, {9'o010, 9'o020, 9'o030, 9'o040, 9'o050, 9'o060, 9'o070, 9'o120}, 8, 8, 1};
    vt[6] = '{2, 5, {9'o223, 9'o223, 9'o223, 9'o223, 9'o223, 9'o0, 9'o0, 9'o0}, 5, 3, 5};
    vt[7] = '{2, 2, {9'o100, 9'o100, 9'o0, 9'o0, 9'o0, 9'o0, 9'o0, 9'o0}, 1, 1, 2};

    reset = 1'b1; start = 1'b0; stall = 1'b0; sel = 0; plen = 8'd1;
    lat_min = 1; lat_max = 3;
    for (int k = 0; k < 256; k++) rom[k] = 9'h0;
    repeat (3) @(negedge clk);
    check("reset rom_addr", addr_a, 0);
    check("reset din", din_a, 0);
    check("reset cpu_run", run_a, 0);
    check("reset busy/halted", {busy_a, halt_a}, 0);
    check("reset instr_cnt", cnt_a, 0);
    check("reset others", {cnt_b, busy_b, halt_b, cnt_c, busy_c, halt_c}, 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      sel = vt[i].sel;
      plen = 8'(vt[i].plen);
      for (int k = 0; k < 256; k++) rom[k] = (k < 8) ? vt[i].w[k[2:0]] : 9'h0;
      run_prog($sformatf("vec%0d", i), (i % 2) == 1);
      check($sformatf("vec%0d table runs", i), run_cnt, vt[i].runs);
      check($sformatf("vec%0d table cnt", i), cnt_m, vt[i].cnt);
      check($sformatf("vec%0d table pc", i), addr_m, vt[i].pc);
    end

    // cpu_done held low in ISSUE
    sel = 0; plen = 8'd1; prot_err = 0;
    for (int k = 0; k < 256; k++) rom[k] = 9'h0;
    rom[0] = 9'o010;
    stall = 1'b1;
    start = 1'b1;
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    ok_stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (run_m !== 1'b0 || addr_m !== 8'd0 || busy_m !== 1'b1) ok_stall = 1'b0;
      @(negedge clk);
    end
    check("stall run low, addr stable", ok_stall, 1);
    stall = 1'b0;
    #1;
    check("stall run on done rise", run_m, 1);
    cyc = 0;
    while (!halt_m && cyc < 200) begin @(negedge clk); cyc++; end
    check("stall halted", halt_m, 1);
    check("stall instr_cnt", cnt_m, 1);
    #3;
    check("stall protocol errors", prot_err, 0);

    // reset in WAIT of the second instruction
    sel = 0; plen = 8'd3; lat_min = 8; lat_max = 8;
    rom[0] = 9'o010; rom[1] = 9'o020; rom[2] = 9'o030;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    seen = 0; cyc = 0;
    while (seen < 2 && cyc < 200) begin
      @(negedge clk); #1;
      if (run_m) seen++;
      cyc++;
    end
    check("rst-test second run seen", seen, 2);
    @(negedge clk);
    @(negedge clk);
    check("rst-test in WAIT busy", {busy_m, run_m}, 2'b10);
    check("rst-test cnt before reset", cnt_m, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst-test busy/halted", {busy_m, halt_m}, 0);
    check("rst-test cpu_run", run_m, 0);
    check("rst-test din", din_m, 0);
    check("rst-test rom_addr", addr_m, 0);
    check("rst-test instr_cnt", cnt_m, 0);
    reset = 1'b0;
    lat_min = 1; lat_max = 3;
    run_prog("rst-test rerun", 1'b0);

    for (int it = 0; it < 25; it++) begin
      sel = int'($urandom_range(2, 0));
      for (int k = 0; k < 256; k++) rom[k] = 9'($urandom);
      if (sel == 0)      plen = 8'($urandom_range(40, 1));
      else if (sel == 1) plen = 8'($urandom_range(7, 0));
      else               plen = 8'($urandom_range(20, 1));
      lat_max = int'($urandom_range(4, 1));
      run_prog($sformatf("rnd%0d", it), 1'($urandom_range(1, 0)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
